// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
// Holds the FSM state type, id-width sizing and packed-bus slice indexing.
package bram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  // Width of an index able to name any of n requesters (at least 1 bit).
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Low bit of slice idx in a packed bus of width-w slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: searches from ptr upward with wrap-around,
// then moves ptr just past the winner whenever a grant is issued.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = id_width(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;

  // A grant is always a transfer, since ready is only raised on a valid bit.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant    = '0;
    ptr_next = ptr;
    idx      = 0;
    found    = 1'b0;
    if (enable) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          ptr_next   = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_next;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block-RAM port among NUM_REQ requesters, routes read data back
// to the issuing requester after the fixed latency, and zero-fills the RAM.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RAM_DEPTH      = 1024,
  parameter int unsigned READ_LATENCY   = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          clear_in,
  output logic                          busy_out,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0]            req_we_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  output logic [ADDR_WIDTH-1:0]         ram_addr_out,
  output logic [DATA_WIDTH-1:0]         ram_din_out,
  output logic                          ram_we_out,
  output logic                          ram_en_out,
  output logic                          ram_regce_out,
  output logic                          ram_rst_out,
  input  logic [DATA_WIDTH-1:0]         ram_dout_in
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam arb_state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    arb_en;
  logic [NUM_REQ-1:0]      grant;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_din;
  logic                    rd_issue;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [NUM_REQ-1:0]      pipe_id [READ_LATENCY];

  assign arb_en        = (state_q == RUN) && !rst_in;
  assign req_ready_out = grant;
  assign ram_regce_out = 1'b1;
  assign ram_rst_out   = rst_in;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk   (clk_in),
    .rst   (rst_in),
    .enable(arb_en),
    .valid (req_valid_in),
    .grant (grant)
  );

  // Pick the granted requester's command off the packed buses.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we   = req_we_in[i];
        sel_addr = req_addr_in[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
        sel_din  = req_wdata_in[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  assign rd_issue = (|grant) && !sel_we;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Next state and RAM port drive.
  always_comb begin
    state_d      = state_q;
    busy_out     = 1'b0;
    ram_en_out   = 1'b0;
    ram_we_out   = 1'b0;
    ram_addr_out = '0;
    ram_din_out  = '0;
    case (state_q)
      CLEAR: begin
        busy_out = 1'b1;
        if (!rst_in) begin
          ram_en_out   = 1'b1;
          ram_we_out   = 1'b1;
          ram_addr_out = clr_cnt;
        end
        if (clr_cnt == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        if (|grant) begin
          ram_en_out   = 1'b1;
          ram_we_out   = sel_we;
          ram_addr_out = sel_addr;
          ram_din_out  = sel_din;
        end
        if (clear_in) state_d = CLEAR;
      end
    endcase
    if (rst_in) busy_out = CLEAR_ON_RESET;
  end

  // Clear counter restarts from 0 every time CLEAR is entered.
  always_ff @(posedge clk_in) begin
    if (rst_in || state_q != CLEAR) clr_cnt <= '0;
    else if (clr_cnt == LAST_ADDR)  clr_cnt <= '0;
    else                            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      for (int unsigned s = 1; s < READ_LATENCY; s++) pipe_vld[s] <= pipe_vld[s-1];
    end
  end

  // Ids need no reset; they are qualified by pipe_vld.
  always_ff @(posedge clk_in) begin
    pipe_id[0] <= grant;
    for (int unsigned s = 1; s < READ_LATENCY; s++) pipe_id[s] <= pipe_id[s-1];
  end

  assign rsp_valid_out = (rst_in || !pipe_vld[READ_LATENCY-1]) ? '0 : pipe_id[READ_LATENCY-1];
  assign rsp_data_out  = ram_dout_in;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: read-first RAM model with output
// register, plus a behavioural reference of arbitration, memory and responses.
module tb_bram_port_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            busy;
  logic [N-1:0]    valid;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic            ram_we;
  logic            ram_en;
  logic            ram_regce;
  logic            ram_rst;
  logic [DW-1:0]   ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .busy_out(busy),
    .req_valid_in(valid), .req_we_in(we), .req_addr_in(addr), .req_wdata_in(wdata),
    .req_ready_out(ready), .rsp_valid_out(rsp_valid), .rsp_data_out(rsp_data),
    .ram_addr_out(ram_addr), .ram_din_out(ram_din), .ram_we_out(ram_we),
    .ram_en_out(ram_en), .ram_regce_out(ram_regce), .ram_rst_out(ram_rst),
    .ram_dout_in(ram_dout)
  );

  // Read-first block RAM with an extra output register (two-cycle read).
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_lat;
  logic [DW-1:0] ram_oreg;
  always @(posedge clk) begin
    if (ram_en) begin
      ram_lat <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
    if (ram_rst)        ram_oreg <= '0;
    else if (ram_regce) ram_oreg <= ram_lat;
  end
  assign ram_dout = ram_oreg;

  // Reference model state.
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr   = 0;
  bit            m_clear = 1'b1;
  int            m_cidx  = 0;
  int            cyc     = 0;
  int            g_idx   = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic sample_check();
    int            g;
    int            j;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rv;
    bit            exp_en;
    bit            exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    g = -1;
    if (!rst && !m_clear) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && valid[j]) g = j;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", 64'(ready), 64'(exp_rdy));
    check("busy", 64'(busy), rst ? 64'd1 : 64'(m_clear));
    exp_en = !rst && (m_clear || g >= 0);
    check("ram_en", 64'(ram_en), 64'(exp_en));
    if (exp_en) begin
      exp_we = m_clear ? 1'b1 : we[g];
      exp_a  = m_clear ? AW'(m_cidx) : addr[g*AW +: AW];
      exp_d  = m_clear ? '0 : wdata[g*DW +: DW];
      check("ram_we", 64'(ram_we), 64'(exp_we));
      check("ram_addr", 64'(ram_addr), 64'(exp_a));
      if (exp_we) check("ram_din", 64'(ram_din), 64'(exp_d));
    end
    exp_rv = '0;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].id] = 1'b1;
      check("rsp_data", 64'(rsp_data), 64'(rq[0].data));
      void'(rq.pop_front());
    end
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    g_idx = g;
  endtask

  task automatic commit();
    rsp_t r;
    int   a;
    if (rst) begin
      m_ptr   = 0;
      m_clear = 1'b1;
      m_cidx  = 0;
      rq.delete();
    end else if (m_clear) begin
      m_mem[m_cidx] = '0;
      if (m_cidx == DEPTH - 1) m_clear = 1'b0;
      else                     m_cidx++;
    end else begin
      if (g_idx >= 0) begin
        a = int'(addr[g_idx*AW +: AW]);
        if (we[g_idx]) begin
          m_mem[a] = wdata[g_idx*DW +: DW];
        end else begin
          r.due  = cyc + LAT;
          r.id   = g_idx;
          r.data = m_mem[a];
          rq.push_back(r);
        end
        m_ptr = (g_idx + 1) % N;
      end
      if (clear) begin
        m_clear = 1'b1;
        m_cidx  = 0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample_check();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drive(input int i, input bit v, input bit w, input int a, input logic [DW-1:0] d);
    valid[i]         = v;
    we[i]            = w;
    addr[i*AW +: AW] = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    clear = 1'b0;
    valid = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // Zero-fill after reset, with requests pending that must not be granted.
    n = 0;
    while (busy && n < 40) begin
      valid = N'($urandom);
      we    = N'($urandom);
      tick();
      n++;
    end
    check("clear_len", 64'(n), 64'(DEPTH));
    valid = '0;
    tick();

    // Write then read-back through a different requester.
    drive(0, 1'b1, 1'b1, 5, 32'hDEADBEEF);
    tick();
    valid = '0;
    drive(1, 1'b1, 1'b0, 5, '0);
    tick();
    valid = '0;
    repeat (3) tick();

    // Continuous contention rotates the grant.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) drive(i, 1'b1, 1'($urandom), int'($urandom_range(0, DEPTH - 1)), $urandom);
      tick();
    end

    // Lone requester 2, then everyone.
    valid = 3'b100;
    we    = '0;
    tick();
    tick();
    valid = 3'b111;
    tick();
    valid = '0;
    repeat (3) tick();

    // Reads in flight across a reset are dropped.
    valid = 3'b111;
    we    = '0;
    tick();
    tick();
    rst   = 1'b1;
    valid = '0;
    tick();
    rst = 1'b0;
    wait_idle();
    valid = 3'b111;
    tick();
    valid = '0;
    repeat (3) tick();

    // Randomised traffic with occasional clears and resets.
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++)
        drive(i, 1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, DEPTH - 1)), $urandom);
      clear = ($urandom_range(0, 119) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    clear = 1'b0;
    rst   = 1'b0;
    valid = '0;
    repeat (4) tick();
    wait_idle();

    // Clear coinciding with a read: old data returns, then zero-fill.
    drive(0, 1'b1, 1'b1, 3, 32'h1234_5678);
    tick();
    drive(0, 1'b1, 1'b1, 4, 32'h9ABC_DEF0);
    tick();
    valid = '0;
    drive(0, 1'b1, 1'b0, 3, '0);
    tick();
    valid = '0;
    drive(1, 1'b1, 1'b0, 4, '0);
    clear = 1'b1;
    tick();
    valid = '0;
    clear = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("reclear_len", 64'(n), 64'(DEPTH));
    drive(2, 1'b1, 1'b0, 3, '0);
    tick();
    valid = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
